// File: rtl/cnu_c2v_msg_gen_10.sv
`default_nettype none
// ============================================================================
// Module   : cnu_c2v_msg_gen_10
// Purpose  : Output end of the row-split CNU10 check-node path. Takes one
//            finalized {m1, m2, min_index} triple per check row into a
//            two-entry ping-pong buffer. It emits the row's 10 check-to-
//            variable magnitudes as 5 beats of 2 messages each.
// Ports    : sys_clk, rstn (async, active low), flush (sync clear)
//            min_valid/min_ready, m1, m2, min_index : triple input
//            c2v_valid/c2v_ready, c2v_msg_0/1,
//            c2v_sub_row, c2v_last                   : beat output
//            idx_err                                 : sticky bad-index flag
// Option   : C2V_OUT_REG_EN adds a registered skid stage on the beat output.
// Revision : 1.0 - initial release
// ============================================================================
module cnu_c2v_msg_gen_10 #(
  parameter int CN_DEGREE        = 10,
  parameter int QUAN_SIZE        = 3,
  parameter int ROW_SPLIT_FACTOR = 5
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 min_valid,
  output logic                 min_ready,
  input  logic [QUAN_SIZE-1:0] m1,
  input  logic [QUAN_SIZE-1:0] m2,
  input  logic [3:0]           min_index,
  output logic                 c2v_valid,
  input  logic                 c2v_ready,
  output logic [QUAN_SIZE-1:0] c2v_msg_0,
  output logic [QUAN_SIZE-1:0] c2v_msg_1,
  output logic [2:0]           c2v_sub_row,
  output logic                 c2v_last,
  output logic                 idx_err
);

  localparam int         EXT_MSG_PARALLELISM = CN_DEGREE / ROW_SPLIT_FACTOR;
  localparam logic [2:0] LAST_BEAT           = 3'(ROW_SPLIT_FACTOR - 1);
  localparam logic [3:0] IDX_LIMIT           = 4'(CN_DEGREE);
  localparam int         DW                  = 2 * QUAN_SIZE + 4;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t               r_state;
  logic [QUAN_SIZE-1:0] r_m1  [2];
  logic [QUAN_SIZE-1:0] r_m2  [2];
  logic [3:0]           r_idx [2];
  logic [1:0]           r_vld;
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [2:0]           r_beat;
  logic                 r_idx_err;

  logic                 w_push;
  logic                 w_int_valid;
  logic                 w_int_ready;
  logic                 w_int_fire;
  logic                 w_last;
  logic                 w_pop;
  logic [QUAN_SIZE-1:0] w_msg [EXT_MSG_PARALLELISM];
  logic [DW-1:0]        w_int_data;

  // Occupancy < 2 means at least one entry is free; depends on state only.
  assign min_ready   = ~(r_vld[0] & r_vld[1]);
  assign w_push      = min_valid & min_ready;
  assign w_int_valid = (r_state == S_EMIT);
  assign w_int_fire  = w_int_valid & w_int_ready;
  assign w_last      = (r_beat == LAST_BEAT);
  assign w_pop       = w_int_fire & w_last;
  assign idx_err     = r_idx_err;

  // Lane j of beat k carries column 2k+j. An out-of-range index never
  // matches any column, so such a row comes out as all m1.
  for (genvar j = 0; j < EXT_MSG_PARALLELISM; j++) begin : g_lane
    logic [3:0] w_col;
    assign w_col    = {r_beat, 1'b0} + 4'(j);
    assign w_msg[j] = (r_idx[r_rd_ptr] == w_col) ? r_m2[r_rd_ptr] : r_m1[r_rd_ptr];
  end

  assign w_int_data = {w_msg[0], w_msg[1], r_beat, w_last};

  // Payload storage: validity is tracked separately, so no reset is needed.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_m1[r_wr_ptr]  <= m1;
      r_m2[r_wr_ptr]  <= m2;
      r_idx[r_wr_ptr] <= min_index;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_vld     <= 2'b00;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_beat    <= 3'd0;
      r_idx_err <= 1'b0;
    end else if (flush) begin
      r_state   <= S_IDLE;
      r_vld     <= 2'b00;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_beat    <= 3'd0;
      r_idx_err <= 1'b0;
    end else begin
      // Push and pop always target different entries when both happen.
      if (w_push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= ~r_wr_ptr;
        if (min_index >= IDX_LIMIT) r_idx_err <= 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= ~r_rd_ptr;
      end
      case (r_state)
        S_IDLE: begin
          // Entering EMIT on the push itself gives one-cycle latency.
          if ((r_vld != 2'b00) || w_push) begin
            r_state <= S_EMIT;
            r_beat  <= 3'd0;
          end
        end
        S_EMIT: begin
          if (w_int_fire) begin
            if (w_last) begin
              r_beat <= 3'd0;
              if (!(r_vld[~r_rd_ptr] || w_push)) r_state <= S_IDLE;
            end else begin
              r_beat <= r_beat + 3'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef C2V_OUT_REG_EN
  // Output register plus one skid entry: the FSM only ever sees whether
  // the skid entry is free, which cuts the c2v_ready timing path.
  logic          r_out_vld;
  logic [DW-1:0] r_out_data;
  logic          r_skid_vld;
  logic [DW-1:0] r_skid_data;

  assign w_int_ready = ~r_skid_vld;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
    end else if (!r_out_vld || c2v_ready) begin
      if (r_skid_vld) begin
        r_out_data <= r_skid_data;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (w_int_fire) begin
        r_out_data <= w_int_data;
        r_out_vld  <= 1'b1;
      end else begin
        r_out_vld  <= 1'b0;
      end
    end else if (w_int_fire) begin
      r_skid_data <= w_int_data;
      r_skid_vld  <= 1'b1;
    end
  end

  assign c2v_valid = r_out_vld;
  assign {c2v_msg_0, c2v_msg_1, c2v_sub_row, c2v_last} = r_out_data;
`else
  assign w_int_ready = c2v_ready;
  assign c2v_valid   = w_int_valid;
  // Outputs are held at zero while idle.
  assign {c2v_msg_0, c2v_msg_1, c2v_sub_row, c2v_last} = w_int_valid ? w_int_data : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cnu_c2v_msg_gen_10.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnu_c2v_msg_gen_10
// Purpose  : Self-checking bench for cnu_c2v_msg_gen_10. It uses directed
//            scenarios followed by random rows. A row-level reference model
//            expands each accepted triple into its expected beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnu_c2v_msg_gen_10;

  logic       sys_clk = 1'b0;
  logic       rstn = 1'b0;
  logic       flush = 1'b0;
  logic       min_valid = 1'b0;
  logic       min_ready;
  logic [2:0] m1 = '0;
  logic [2:0] m2 = '0;
  logic [3:0] min_index = '0;
  logic       c2v_valid;
  logic       c2v_ready = 1'b0;
  logic [2:0] c2v_msg_0;
  logic [2:0] c2v_msg_1;
  logic [2:0] c2v_sub_row;
  logic       c2v_last;
  logic       idx_err;

  cnu_c2v_msg_gen_10 dut (
    .sys_clk    (sys_clk),
    .rstn       (rstn),
    .flush      (flush),
    .min_valid  (min_valid),
    .min_ready  (min_ready),
    .m1         (m1),
    .m2         (m2),
    .min_index  (min_index),
    .c2v_valid  (c2v_valid),
    .c2v_ready  (c2v_ready),
    .c2v_msg_0  (c2v_msg_0),
    .c2v_msg_1  (c2v_msg_1),
    .c2v_sub_row(c2v_sub_row),
    .c2v_last   (c2v_last),
    .idx_err    (idx_err)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference state: expected beats {msg_0, msg_1, sub_row, last}, the
  // number of rows still held by the buffer, and the sticky error flag.
  logic [9:0]  exp_q[$];
  int          rows_m = 0;
  bit          err_m  = 1'b0;
  logic [10:0] stim_q[$];   // pending triples {m1, m2, idx}

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // A row is 10 columns; the column equal to idx gets m2, all others m1.
  task automatic add_row(input logic [2:0] a, input logic [2:0] b, input logic [3:0] ix);
    logic [2:0] col_msg [10];
    for (int c = 0; c < 10; c++) col_msg[c] = (int'(ix) == c) ? b : a;
    for (int k = 0; k < 5; k++)
      exp_q.push_back({col_msg[2*k], col_msg[2*k+1], 3'(k), (k == 4)});
  endtask

  task automatic clear_model();
    exp_q.delete();
    rows_m = 0;
    err_m  = 1'b0;
  endtask

  // One clock cycle: drive just after the edge, sample once settled.
  task automatic cycle(input logic mv, input logic [2:0] a, input logic [2:0] b,
                       input logic [3:0] ix, input logic rdy, input logic fl,
                       output bit pushed);
    bit ready_m;
    @(posedge sys_clk);
    #1;
    min_valid = mv; m1 = a; m2 = b; min_index = ix; c2v_ready = rdy; flush = fl;
    #1;
`ifndef C2V_OUT_REG_EN
    check_val("min_ready", min_ready, (rows_m < 2));
    check_val("c2v_valid", c2v_valid, (exp_q.size() > 0));
    ready_m = (rows_m < 2);
`else
    ready_m = min_ready;
`endif
    check_val("idx_err", idx_err, err_m);
    if (c2v_valid) begin
      if (exp_q.size() == 0) check_val("spurious_beat", c2v_valid, 1'b0);
      else check_val("beat", {c2v_msg_0, c2v_msg_1, c2v_sub_row, c2v_last}, exp_q[0]);
    end
    pushed = 1'b0;
    if (fl) begin
      clear_model();
    end else begin
      if (c2v_valid && rdy && exp_q.size() > 0) begin
        if (exp_q[0][0]) rows_m--;
        void'(exp_q.pop_front());
      end
      if (mv && ready_m) begin
        add_row(a, b, ix);
        rows_m++;
        if (ix >= 4'd10) err_m = 1'b1;
        pushed = 1'b1;
      end
    end
  endtask

  // Offer queued triples (held stable until accepted) for n cycles.
  task automatic run(input int n, input int ready_pct, input int new_pct);
    bit pushed;
    for (int i = 0; i < n; i++) begin
      if (new_pct > 0 && stim_q.size() < 2 && int'($urandom_range(99)) < new_pct)
        stim_q.push_back({3'($urandom_range(7)), 3'($urandom_range(7)), 4'($urandom_range(12))});
      if (stim_q.size() > 0)
        cycle(1'b1, stim_q[0][10:8], stim_q[0][7:5], stim_q[0][3:0] | {3'b0, 1'b0},
              (int'($urandom_range(99)) < ready_pct), 1'b0, pushed);
      else
        cycle(1'b0, 3'd0, 3'd0, 4'd0, (int'($urandom_range(99)) < ready_pct), 1'b0, pushed);
      if (pushed) void'(stim_q.pop_front());
    end
  endtask

  task automatic drain();
    int budget = 60;
    while ((exp_q.size() > 0 || stim_q.size() > 0) && budget > 0) begin
      run(1, 100, 0);
      budget--;
    end
    check_val("drain_empty", exp_q.size() + stim_q.size(), 0);
  endtask

  task automatic async_reset_midcycle();
    @(posedge sys_clk);
    #3;
    rstn = 1'b0;
    #1;
    check_val("arst_valid", c2v_valid, 1'b0);
    check_val("arst_min_ready", min_ready, 1'b1);
    check_val("arst_idx_err", idx_err, 1'b0);
    check_val("arst_outputs", {c2v_msg_0, c2v_msg_1, c2v_sub_row, c2v_last}, 10'd0);
    clear_model();
    stim_q.delete();
    min_valid = 1'b0; flush = 1'b0; c2v_ready = 1'b0;
    @(posedge sys_clk);
    #3;
    rstn = 1'b1;
  endtask

  bit pushed;
  logic [0:0] bp_pat [12] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1};

  initial begin
    // Reset state, observed while reset is still applied.
    #2;
    check_val("rst_valid", c2v_valid, 1'b0);
    check_val("rst_min_ready", min_ready, 1'b1);
    check_val("rst_idx_err", idx_err, 1'b0);
    check_val("rst_outputs", {c2v_msg_0, c2v_msg_1, c2v_sub_row, c2v_last}, 10'd0);
    repeat (2) @(posedge sys_clk);
    #3;
    rstn = 1'b1;

    // Single row, always ready.
    stim_q.push_back({3'd1, 3'd4, 1'b0, 4'd6});
    run(8, 100, 0);

    // Back-to-back rows.
    stim_q.push_back({3'd2, 3'd5, 1'b0, 4'd0});
    stim_q.push_back({3'd0, 3'd3, 1'b0, 4'd9});
    run(14, 100, 0);

    // Backpressure on beats 1 and 3.
    cycle(1'b1, 3'd6, 3'd2, 4'd3, 1'b0, 1'b0, pushed);
    for (int i = 0; i < 12; i++) cycle(1'b0, 3'd0, 3'd0, 4'd0, bp_pat[i][0], 1'b0, pushed);
    drain();

    // Three triples offered while the consumer stalls: the third waits.
    stim_q.push_back({3'd1, 3'd2, 1'b0, 4'd1});
    stim_q.push_back({3'd3, 3'd4, 1'b0, 4'd4});
    stim_q.push_back({3'd5, 3'd6, 1'b0, 4'd8});
    run(4, 0, 0);
    run(30, 100, 0);
    drain();

    // Bad index, then flush mid-row.
    cycle(1'b1, 3'd3, 3'd7, 4'd12, 1'b1, 1'b0, pushed);
    cycle(1'b0, 3'd0, 3'd0, 4'd0, 1'b1, 1'b0, pushed);
    cycle(1'b0, 3'd0, 3'd0, 4'd0, 1'b1, 1'b0, pushed);
    cycle(1'b1, 3'd2, 3'd1, 4'd5, 1'b1, 1'b1, pushed);
    run(3, 100, 0);

    // Asynchronous reset during beat 2, then a fresh row.
    stim_q.push_back({3'd4, 3'd1, 1'b0, 4'd2});
    run(3, 100, 0);
    async_reset_midcycle();
    run(2, 100, 0);
    stim_q.push_back({3'd7, 3'd0, 1'b0, 4'd7});
    run(8, 100, 0);

    // Randomized traffic.
    run(600, 70, 50);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
